// File: rtl/uart_tx_frame_param_if.sv
// Producer-side handshake bundle for the parametrised UART transmitter.
// The producer holds tx_data/tx_valid until tx_valid && tx_ready is seen at a
// rising clock edge.
interface uart_tx_frame_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_frame_param.sv
// Parametrised UART transmitter.
// - Accepts words over a valid/ready handshake.
// - Has a one-entry holding buffer, so a word queued during a frame follows it
//   with no idle gap.
// - Frame layout: start bit, DATA_BITS data bits (LSB first), an optional
//   even/odd parity bit, then STOP_BITS stop bits.
// - Every bit lasts CLKS_PER_BIT clocks. All outputs are registered.
module uart_tx_frame_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_frame_param_if.slave  tx,
  output logic                  tx_line,
  output logic                  busy,
  output logic                  finish
);

  // Parameter legality is enforced at elaboration; there is no runtime fallback.
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_frame_param: illegal parameter combination");
  end

  localparam int BAUD_W = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state_q;
  logic [BAUD_W-1:0]      baud_q;
  logic [BAUD_W-1:0]      baud_d;
  logic [3:0]             bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic [DATA_BITS-1:0]   buf_q;
  logic                   buf_full_q;
  logic                   tx_ready_q;
  logic                   tx_line_q;
  logic                   busy_q;
  logic                   finish_q;
  logic                   accept;
  logic                   last_tick;

  // Parity bit for a word being loaded into the shifter.
  // Mode 2 is odd parity; any other mode yields the even parity bit.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    if (PARITY_MODE == 2) begin
      return ~^d;
    end
    return ^d;
  endfunction

  // Handshake qualifier and baud-counter next state.
  // Every state change happens on the last tick of a bit, so the wrap to 0 on
  // that tick doubles as the counter restart on state entry.
  always_comb begin
    accept    = tx.tx_valid & tx_ready_q;
    last_tick = (baud_q == BAUD_LAST);
    baud_d    = baud_q + 1'b1;
    if (state_q == ST_IDLE || last_tick) begin
      baud_d = '0;
    end
  end

  // Frame sequencer, holding buffer and registered line/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      buf_full_q <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_line_q  <= 1'b1;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      finish_q <= 1'b0;

      // Any word accepted while not idle is parked in the holding buffer.
      if (accept && state_q != ST_IDLE) begin
        buf_q      <= tx.tx_data;
        buf_full_q <= 1'b1;
        tx_ready_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          tx_line_q <= 1'b1;
          // A word can be parked as the previous frame finishes; send it now.
          if (buf_full_q) begin
            shift_q    <= buf_q;
            par_q      <= parity_of(buf_q);
            buf_full_q <= 1'b0;
            tx_ready_q <= 1'b1;
            bit_q      <= '0;
            state_q    <= ST_START;
            tx_line_q  <= 1'b0;
            busy_q     <= 1'b1;
          end else if (accept) begin
            shift_q   <= tx.tx_data;
            par_q     <= parity_of(tx.tx_data);
            bit_q     <= '0;
            state_q   <= ST_START;
            tx_line_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        ST_START: begin
          if (last_tick) begin
            bit_q     <= '0;
            state_q   <= ST_DATA;
            tx_line_q <= shift_q[0];
          end
        end

        ST_DATA: begin
          if (last_tick) begin
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY_MODE != 0) begin
                state_q   <= ST_PARITY;
                tx_line_q <= par_q;
              end else begin
                state_q   <= ST_STOP;
                tx_line_q <= 1'b1;
              end
            end else begin
              bit_q     <= bit_q + 4'd1;
              shift_q   <= shift_q >> 1;
              tx_line_q <= shift_q[1];
            end
          end
        end

        ST_PARITY: begin
          if (last_tick) begin
            bit_q     <= '0;
            state_q   <= ST_STOP;
            tx_line_q <= 1'b1;
          end
        end

        ST_STOP: begin
          if (last_tick) begin
            if (bit_q == STOP_LAST) begin
              finish_q <= 1'b1;
              bit_q    <= '0;
              if (buf_full_q) begin
                // Back-to-back: the next start bit follows with no gap.
                shift_q    <= buf_q;
                par_q      <= parity_of(buf_q);
                buf_full_q <= 1'b0;
                tx_ready_q <= 1'b1;
                state_q    <= ST_START;
                tx_line_q  <= 1'b0;
              end else begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                tx_line_q <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          tx_line_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx.tx_ready = tx_ready_q;
  assign tx_line     = tx_line_q;
  assign busy        = busy_q;
  assign finish      = finish_q;

endmodule

// File: tb/tb_uart_tx_frame_param.sv
// Bench for uart_tx_frame_param: four instances with CLKS_PER_BIT=16 cover
// even/odd/no parity and the 7-bit, two-stop-bit variant.
module tb_uart_tx_frame_param;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_frame_param_if #(.DATA_BITS(8)) if0 (), if1 (), if2 ();
  uart_tx_frame_param_if #(.DATA_BITS(7)) if3 ();

  wire [3:0] line_w, busy_w, fin_w, rdy_w;
  assign rdy_w = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

  // k=0: 8 bits, even parity, 1 stop
  uart_tx_frame_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .tx(if0), .tx_line(line_w[0]), .busy(busy_w[0]), .finish(fin_w[0]));
  // k=1: 8 bits, odd parity, 1 stop
  uart_tx_frame_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) d1 (
    .clk(clk), .rst(rst), .tx(if1), .tx_line(line_w[1]), .busy(busy_w[1]), .finish(fin_w[1]));
  // k=2: 8 bits, no parity, 1 stop
  uart_tx_frame_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) d2 (
    .clk(clk), .rst(rst), .tx(if2), .tx_line(line_w[2]), .busy(busy_w[2]), .finish(fin_w[2]));
  // k=3: 7 bits, no parity, 2 stop
  uart_tx_frame_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) d3 (
    .clk(clk), .rst(rst), .tx(if3), .tx_line(line_w[3]), .busy(busy_w[3]), .finish(fin_w[3]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [8:0] d);
    case (k)
      0: begin if0.tx_valid = v; if0.tx_data = d[7:0]; end
      1: begin if1.tx_valid = v; if1.tx_data = d[7:0]; end
      2: begin if2.tx_valid = v; if2.tx_data = d[7:0]; end
      default: begin if3.tx_valid = v; if3.tx_data = d[6:0]; end
    endcase
  endtask

  // bits: expected line value per bit slot, slot 0 = start bit.
  // fin_at: edges after the accepting edge at which finish is seen high.
  typedef struct {
    int         k;
    logic [8:0] data;
    int         nbits;
    logic [11:0] bits;
    int         fin_at;
  } vec_t;

  vec_t vecs[7];

  // Sends one word, then scrambles tx_data (which must not affect the frame).
  // Captures the line at the first and last cycle of each bit slot.
  task automatic run_frame(input int i, input string tag);
    vec_t v;
    logic [11:0] cs;
    logic [11:0] ce;
    int fcnt;
    int fpos;
    v = vecs[i];
    cs = '0;
    ce = '0;
    fcnt = 0;
    fpos = -1;
    check({tag, "_ready_pre"}, 64'(rdy_w[v.k]), 64'd1);
    drive(v.k, 1'b1, v.data);
    @(posedge clk); #1;
    drive(v.k, 1'b0, ~v.data);
    check({tag, "_first_fall"}, 64'(line_w[v.k]), 64'd0);
    for (int n = 0; n <= v.nbits * CPB + 2; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (n < v.nbits * CPB) begin
        if (n % CPB == 0)       cs[n / CPB] = line_w[v.k];
        if (n % CPB == CPB - 1) ce[n / CPB] = line_w[v.k];
      end
      if (fin_w[v.k]) begin
        fcnt++;
        fpos = n;
      end
      if (n == v.nbits * CPB - 1) check({tag, "_busy_last"}, 64'(busy_w[v.k]), 64'd1);
      if (n == v.nbits * CPB) begin
        check({tag, "_busy_after"}, 64'(busy_w[v.k]), 64'd0);
        check({tag, "_line_idle"}, 64'(line_w[v.k]), 64'd1);
        check({tag, "_ready_after"}, 64'(rdy_w[v.k]), 64'd1);
      end
    end
    check({tag, "_bits_first_cycle"}, 64'(cs), 64'(v.bits));
    check({tag, "_bits_last_cycle"}, 64'(ce), 64'(v.bits));
    check({tag, "_finish_count"}, 64'(fcnt), 64'd1);
    check({tag, "_finish_edge"}, 64'(fpos), 64'(v.fin_at));
  endtask

  initial begin
    logic [8:0]  words[3];
    int          acc_n[3];
    int          fposa[3];
    int          widx;
    int          fcnt;
    int          blow;
    int          lowcnt;
    logic        pre;
    logic [32:0] cap;

    // 0xA5 even: 0,1,0,1,0,0,1,0,1,0,1
    vecs[0] = '{k: 0, data: 9'h0A5, nbits: 11, bits: 12'h54A, fin_at: 176};
    // 0x01 odd: parity 0
    vecs[1] = '{k: 1, data: 9'h001, nbits: 11, bits: 12'h402, fin_at: 176};
    // 0x01 even: parity 1
    vecs[2] = '{k: 0, data: 9'h001, nbits: 11, bits: 12'h602, fin_at: 176};
    // 0x3C no parity: 0,0,0,1,1,1,1,0,0,1
    vecs[3] = '{k: 2, data: 9'h03C, nbits: 10, bits: 12'h278, fin_at: 160};
    // 7 bits 0x7F, 2 stop: 0,1111111,1,1
    vecs[4] = '{k: 3, data: 9'h07F, nbits: 10, bits: 12'h3FE, fin_at: 160};
    // 7 bits 0x55, 2 stop: 0,1,0,1,0,1,0,1,1,1
    vecs[5] = '{k: 3, data: 9'h055, nbits: 10, bits: 12'h3AA, fin_at: 160};
    // 0xFF odd: parity 1
    vecs[6] = '{k: 1, data: 9'h0FF, nbits: 11, bits: 12'h7FE, fin_at: 176};

    rst = 1'b1;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 9'h000);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_outputs_k%0d", k),
            64'({line_w[k], rdy_w[k], busy_w[k], fin_w[k]}), 64'b1100);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_frame(i, $sformatf("vec%0d", i));
    end

    // Back-to-back: producer holds valid with 0x11, 0x22, 0x33 on instance 0.
    words[0] = 9'h011;
    words[1] = 9'h022;
    words[2] = 9'h033;
    for (int j = 0; j < 3; j++) begin
      acc_n[j] = -1;
      fposa[j] = -1;
    end
    widx = 0;
    fcnt = 0;
    blow = 0;
    cap  = '0;
    drive(0, 1'b1, words[0]);
    for (int n = 0; n <= 540; n++) begin
      pre = if0.tx_valid & rdy_w[0];
      @(posedge clk); #1;
      if (pre) begin
        acc_n[widx] = n;
        widx++;
        if (widx == 3) drive(0, 1'b0, 9'h000);
        else           drive(0, 1'b1, words[widx]);
      end
      if (n == 1) check("b2b_ready_low_when_buffered", 64'(rdy_w[0]), 64'd0);
      if (n % CPB == 8 && n / CPB < 33) cap[n / CPB] = line_w[0];
      if (fin_w[0]) begin
        if (fcnt < 3) fposa[fcnt] = n;
        fcnt++;
      end
      if (n < 528 && !busy_w[0]) blow++;
      if (n == 528) check("b2b_busy_after", 64'(busy_w[0]), 64'd0);
    end
    check("b2b_accept0", 64'(acc_n[0]), 64'd0);
    check("b2b_accept1", 64'(acc_n[1]), 64'd1);
    check("b2b_accept2", 64'(acc_n[2]), 64'd177);
    check("b2b_stream", 64'(cap), 64'({11'h466, 11'h444, 11'h422}));
    check("b2b_finish_count", 64'(fcnt), 64'd3);
    check("b2b_finish0", 64'(fposa[0]), 64'd176);
    check("b2b_finish1", 64'(fposa[1]), 64'd352);
    check("b2b_finish2", 64'(fposa[2]), 64'd528);
    check("b2b_busy_gaps", 64'(blow), 64'd0);

    // Reset mid-DATA with a word sitting in the buffer.
    @(posedge clk); #1;
    drive(0, 1'b1, 9'h05A);
    @(posedge clk); #1;
    drive(0, 1'b1, 9'h077);
    @(posedge clk); #1;
    drive(0, 1'b0, 9'h000);
    check("rstmid_buffered", 64'(rdy_w[0]), 64'd0);
    repeat (48) @(posedge clk);
    #1;
    check("rstmid_busy_before", 64'(busy_w[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_outputs", 64'({line_w[0], rdy_w[0], busy_w[0], fin_w[0]}), 64'b1100);
    lowcnt = 0;
    fcnt   = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (!line_w[0]) lowcnt++;
      if (fin_w[0] || busy_w[0]) fcnt++;
    end
    check("rstmid_line_stays_idle", 64'(lowcnt), 64'd0);
    check("rstmid_no_finish_or_busy", 64'(fcnt), 64'd0);

    // The instance is usable again after the abort.
    run_frame(0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
